// File: rtl/ysyx_22040750_pc_fetch_if.sv
// Fetch front-end channel bundle: dnpc handshake in, imem request/response, IF/ID handshake out.
// slave = the fetch block itself, master = whoever drives its inputs.
interface ysyx_22040750_pc_fetch_if;
  logic        I_dnpc_valid;
  logic        O_dnpc_ready;
  logic [31:0] I_dnpc;
  logic        O_imem_req_valid;
  logic        I_imem_req_ready;
  logic [31:0] O_imem_addr;
  logic        I_imem_resp_valid;
  logic [31:0] I_imem_rdata;
  logic        I_flush;
  logic        O_IF_ID_valid;
  logic        I_IF_ID_ready;
  logic [31:0] O_pc;
  logic [31:0] O_snpc;
  logic [31:0] O_inst;

  modport slave (
    input  I_dnpc_valid, I_dnpc, I_imem_req_ready, I_imem_resp_valid, I_imem_rdata,
    input  I_flush, I_IF_ID_ready,
    output O_dnpc_ready, O_imem_req_valid, O_imem_addr, O_IF_ID_valid, O_pc, O_snpc, O_inst
  );

  modport master (
    output I_dnpc_valid, I_dnpc, I_imem_req_ready, I_imem_resp_valid, I_imem_rdata,
    output I_flush, I_IF_ID_ready,
    input  O_dnpc_ready, O_imem_req_valid, O_imem_addr, O_IF_ID_valid, O_pc, O_snpc, O_inst
  );
endinterface

// File: rtl/ysyx_22040750_pc_fetch.sv
// PC register and single-outstanding instruction fetch: takes the next PC, fetches it, and
// presents instruction/pc/snpc to IF/ID. A flush while a fetch is in flight poisons its response.
module ysyx_22040750_pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic                      I_clk,
  input logic                      I_rst,
  ysyx_22040750_pc_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_NEXT = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_snpc;
  logic [31:0] r_inst;
  logic        r_drop;
  logic        r_req_valid;
  logic        r_if_id_valid;
  logic        r_dnpc_ready;

  logic [31:0] w_dnpc;
  logic [31:0] w_next_pc;

  assign w_dnpc    = bus.I_dnpc;
  assign w_next_pc = w_dnpc & 32'hFFFF_FFFC;

  assign bus.O_imem_req_valid = r_req_valid;
  assign bus.O_imem_addr      = r_pc;
  assign bus.O_dnpc_ready     = r_dnpc_ready;
  assign bus.O_IF_ID_valid    = r_if_id_valid;
  assign bus.O_pc             = r_pc;
  assign bus.O_snpc           = r_snpc;
  assign bus.O_inst           = r_inst;

  // Fetch sequencer; all outputs are registered alongside the state they belong to.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_snpc        <= RESET_PC + 32'd4;
      r_inst        <= 32'd0;
      r_drop        <= 1'b0;
      r_req_valid   <= 1'b1;
      r_if_id_valid <= 1'b0;
      r_dnpc_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          // A flush here poisons the response of this very request, accepted or not.
          r_drop <= r_drop | bus.I_flush;
          if (bus.I_imem_req_ready) begin
            r_state     <= S_WAIT;
            r_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.I_imem_resp_valid) begin
            r_drop <= 1'b0;
            if (r_drop || bus.I_flush) begin
              r_state      <= S_NEXT;
              r_dnpc_ready <= 1'b1;
            end else begin
              r_inst        <= bus.I_imem_rdata;
              r_state       <= S_HOLD;
              r_if_id_valid <= 1'b1;
            end
          end else if (bus.I_flush) begin
            r_drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.I_flush || bus.I_IF_ID_ready) begin
            r_state       <= S_NEXT;
            r_if_id_valid <= 1'b0;
            r_dnpc_ready  <= 1'b1;
          end
        end
        S_NEXT: begin
          if (bus.I_dnpc_valid) begin
            r_pc         <= w_next_pc;
            r_snpc       <= w_next_pc + 32'd4;
            r_state      <= S_REQ;
            r_req_valid  <= 1'b1;
            r_dnpc_ready <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_REQ;
          r_drop        <= 1'b0;
          r_req_valid   <= 1'b1;
          r_if_id_valid <= 1'b0;
          r_dnpc_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_pc_fetch.sv
// Bench for ysyx_22040750_pc_fetch: directed vector table, reset corner cases, and
// randomized traffic against a transaction-level reference model.
module tb_ysyx_22040750_pc_fetch;

  typedef struct packed {
    logic        dnpc_valid;
    logic [31:0] dnpc;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        flush;
    logic        ifid_ready;
  } ins_t;

  typedef struct packed {
    logic        req_valid;
    logic [31:0] addr;
    logic        ifid_valid;
    logic        dnpc_ready;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic [31:0] inst;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
  } vec_t;

  localparam logic [31:0] P0 = 32'h8000_0000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  vec_t vecs[$];

  // reference model: which of the four obligations is pending, plus fetched data
  logic        m_need_pc, m_req_out, m_holding, m_discard;
  logic [31:0] m_pc, m_inst;

  ysyx_22040750_pc_fetch_if bus ();

  ysyx_22040750_pc_fetch #(.RESET_PC(P0)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t get_act();
    outs_t o;
    o.req_valid  = bus.O_imem_req_valid;
    o.addr       = bus.O_imem_addr;
    o.ifid_valid = bus.O_IF_ID_valid;
    o.dnpc_ready = bus.O_dnpc_ready;
    o.pc         = bus.O_pc;
    o.snpc       = bus.O_snpc;
    o.inst       = bus.O_inst;
    return o;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got req=%b addr=%h ifid=%b rdy=%b pc=%h snpc=%h inst=%h, expected req=%b addr=%h ifid=%b rdy=%b pc=%h snpc=%h inst=%h",
               name, act.req_valid, act.addr, act.ifid_valid, act.dnpc_ready, act.pc, act.snpc, act.inst,
               exp.req_valid, exp.addr, exp.ifid_valid, exp.dnpc_ready, exp.pc, exp.snpc, exp.inst);
    end
  endtask

  task automatic apply_in(input ins_t in);
    bus.I_dnpc_valid      = in.dnpc_valid;
    bus.I_dnpc            = in.dnpc;
    bus.I_imem_req_ready  = in.req_ready;
    bus.I_imem_resp_valid = in.resp_valid;
    bus.I_imem_rdata      = in.rdata;
    bus.I_flush           = in.flush;
    bus.I_IF_ID_ready     = in.ifid_ready;
  endtask

  task automatic add(input logic dv, input logic [31:0] dnpc, input logic rr, input logic rv,
                     input logic [31:0] rdata, input logic fl, input logic ir,
                     input logic e_rv, input logic [31:0] e_addr, input logic e_iv, input logic e_dr,
                     input logic [31:0] e_snpc, input logic [31:0] e_inst);
    vec_t v;
    v.in  = '{dnpc_valid: dv, dnpc: dnpc, req_ready: rr, resp_valid: rv, rdata: rdata, flush: fl, ifid_ready: ir};
    v.exp = '{req_valid: e_rv, addr: e_addr, ifid_valid: e_iv, dnpc_ready: e_dr, pc: e_addr, snpc: e_snpc, inst: e_inst};
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    m_need_pc = 1'b0;
    m_req_out = 1'b1;
    m_holding = 1'b0;
    m_discard = 1'b0;
    m_pc      = P0;
    m_inst    = 32'd0;
  endtask

  // One clock of the fetch rules, applied to the inputs present before the edge.
  task automatic model_step(input ins_t in);
    if (m_need_pc) begin
      if (in.dnpc_valid) begin
        m_pc      = {in.dnpc[31:2], 2'b00};
        m_need_pc = 1'b0;
        m_req_out = 1'b1;
      end
    end else if (m_req_out) begin
      if (in.flush) m_discard = 1'b1;
      if (in.req_ready) m_req_out = 1'b0;
    end else if (m_holding) begin
      if (in.flush || in.ifid_ready) begin
        m_holding = 1'b0;
        m_need_pc = 1'b1;
      end
    end else begin
      if (in.resp_valid) begin
        if (m_discard || in.flush) begin
          m_discard = 1'b0;
          m_need_pc = 1'b1;
        end else begin
          m_inst    = in.rdata;
          m_holding = 1'b1;
        end
      end else if (in.flush) begin
        m_discard = 1'b1;
      end
    end
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    o.req_valid  = m_req_out;
    o.addr       = m_pc;
    o.ifid_valid = m_holding;
    o.dnpc_ready = m_need_pc;
    o.pc         = m_pc;
    o.snpc       = m_pc + 32'd4;
    o.inst       = m_inst;
    return o;
  endfunction

  initial begin
    outs_t rst_outs;
    ins_t  idle;
    ins_t  r;
    checks   = 0;
    failures = 0;
    idle     = '0;
    rst_outs = '{req_valid: 1'b1, addr: P0, ifid_valid: 1'b0, dnpc_ready: 1'b0,
                 pc: P0, snpc: 32'h8000_0004, inst: 32'd0};

    //  dv    dnpc          rr    rv    rdata         fl    ir   | req  addr          ifid  rdy   snpc          inst
    add(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, P0,           1'b0, 1'b0, 32'h8000_0004, 32'd0);
    add(1'b0, 32'd0,        1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 1'b0, P0,          1'b1, 1'b0, 32'h8000_0004, 32'h0000_0013);
    for (int i = 0; i < 3; i++)
      add(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0,     1'b0, 1'b0, 1'b0, P0,           1'b1, 1'b0, 32'h8000_0004, 32'h0000_0013);
    add(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0, P0,           1'b0, 1'b1, 32'h8000_0004, 32'h0000_0013);
    add(1'b1, 32'h8000_0011, 1'b0, 1'b0, 32'd0,       1'b0, 1'b0, 1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'h8000_0014, 32'h0000_0013);
    add(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 32'h8000_0010, 1'b0, 1'b0, 32'h8000_0014, 32'h0000_0013);
    add(1'b0, 32'd0,        1'b0, 1'b1, 32'hAABB_CCDD, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 1'b1, 1'b0, 32'h8000_0014, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 32'h8000_0010, 1'b0, 1'b1, 32'h8000_0014, 32'hAABB_CCDD);
    add(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0,       1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_0000, 32'hAABB_CCDD);
    add(1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'd0,       1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'h8000_0104, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 32'h8000_0100, 1'b0, 1'b0, 32'h8000_0104, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 32'h8000_0100, 1'b0, 1'b0, 32'h8000_0104, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 32'h8000_0100, 1'b0, 1'b0, 32'h8000_0104, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 1'b0, 1'b1, 32'h8000_0104, 32'hAABB_CCDD);
    add(1'b1, 32'h8000_0202, 1'b0, 1'b0, 32'd0,       1'b0, 1'b0, 1'b1, 32'h8000_0200, 1'b0, 1'b0, 32'h8000_0204, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 32'h8000_0200, 1'b0, 1'b0, 32'h8000_0204, 32'hAABB_CCDD);
    add(1'b0, 32'd0,        1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h8000_0200, 1'b1, 1'b0, 32'h8000_0204, 32'h1111_1111);
    add(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 32'h8000_0200, 1'b0, 1'b1, 32'h8000_0204, 32'h1111_1111);
    add(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 32'h8000_0200, 1'b0, 1'b1, 32'h8000_0204, 32'h1111_1111);
    add(1'b1, 32'h8000_0300, 1'b0, 1'b0, 32'd0,       1'b0, 1'b0, 1'b1, 32'h8000_0300, 1'b0, 1'b0, 32'h8000_0304, 32'h1111_1111);
    add(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 32'h8000_0300, 1'b0, 1'b0, 32'h8000_0304, 32'h1111_1111);

    rst = 1'b1;
    apply_in(idle);
    #18;
    check("reset_state", get_act(), rst_outs);
    #4 rst = 1'b0;

    foreach (vecs[i]) begin
      apply_in(vecs[i].in);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), get_act(), vecs[i].exp);
    end

    // async reset while waiting for a response, then a stale response must be ignored
    apply_in(idle);
    #3 rst = 1'b1;
    #1 check("async_reset_now", get_act(), rst_outs);
    @(posedge clk);
    #3 rst = 1'b0;
    r = idle;
    r.resp_valid = 1'b1;
    r.rdata      = 32'h0BAD_0BAD;
    apply_in(r);
    @(posedge clk);
    #1 check("late_resp_ignored", get_act(), rst_outs);
    apply_in(idle);
    @(posedge clk);
    #1 check("late_resp_settled", get_act(), rst_outs);

    // randomized traffic against the reference model
    #2 rst = 1'b1;
    model_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    check("rand_reset", get_act(), model_outs());
    for (int n = 0; n < 400; n++) begin
      r.dnpc_valid = 1'($urandom % 2);
      r.dnpc       = $urandom;
      r.req_ready  = (($urandom % 3) != 0);
      r.resp_valid = (($urandom % 3) == 0);
      r.rdata      = $urandom;
      r.flush      = (($urandom % 8) == 0);
      r.ifid_ready = 1'($urandom % 2);
      apply_in(r);
      model_step(r);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d", n), get_act(), model_outs());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
